// File: rtl/wb_commit_buffer_pkg.sv
// Shared types for the writeback commit buffer: occupancy states, widths and
// the buffered entry layout.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              we;
    } entry_t;

endpackage

// File: rtl/wb_commit_buffer_if.sv
// MEM-stage input handshake, register-file write port, forwarding tap and
// commit counter of the writeback commit buffer.
interface wb_commit_buffer_if;
    import wb_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_W-1:0]  rd;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       commit_count;

    modport slave (
        input  in_valid, alu_result, mem_rdata, mem_to_reg, reg_write, rd,
               flush, out_ready,
        output in_ready, out_valid, rf_we, rf_waddr, rf_wdata,
               fwd_valid, fwd_rd, fwd_data, commit_count
    );

    modport master (
        output in_valid, alu_result, mem_rdata, mem_to_reg, reg_write, rd,
               flush, out_ready,
        input  in_ready, out_valid, rf_we, rf_waddr, rf_wdata,
               fwd_valid, fwd_rd, fwd_data, commit_count
    );

endinterface

// File: rtl/wb_commit_buffer_fifo.sv
// Two-entry FIFO holding writeback entries between MEM and the register file.
//   state    | meaning
//   ST_EMPTY | no entry buffered
//   ST_ONE   | one entry, it is the head
//   ST_FULL  | two entries, head is the older one
module wb_skid_fifo
    import wb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t push_entry,
    output entry_t head,
    output state_t state
);

    state_t state_q, state_d;
    entry_t mem_q [2];
    logic   wr_ptr_q, rd_ptr_q;
    logic   push_ok, pop_ok;

    // Never overfill or underflow, whatever the caller asks for.
    assign push_ok = push && (state_q != ST_FULL);
    assign pop_ok  = pop && (state_q != ST_EMPTY);
    assign head    = mem_q[rd_ptr_q];
    assign state   = state_q;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Next occupancy from push/pop; flush empties regardless.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (push_ok) state_d = ST_ONE;
            ST_ONE: begin
                if (push_ok && !pop_ok)      state_d = ST_FULL;
                else if (!push_ok && pop_ok) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop_ok) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Entry storage and ring pointers; reset clears storage so the write
    // port and forwarding tap read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// Writeback commit buffer: selects load vs ALU data, qualifies the register
// write, buffers up to two results and drains them into the register file.
module wb_commit_buffer
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    wb_commit_buffer_if.slave bus
);

    entry_t      in_entry, head;
    state_t      state;
    logic        accept, pop;
    logic [31:0] commit_count_q;

    assign in_entry.data = bus.mem_to_reg ? bus.mem_rdata : bus.alu_result;
    assign in_entry.rd   = bus.rd;
    assign in_entry.we   = bus.reg_write && (bus.rd != REG_ZERO);

    // Ready comes from registered state only, so in_valid never loops
    // combinationally back to any output.
    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);

    // A flush drops the incoming result but still lets the head commit.
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop    = bus.out_valid && bus.out_ready;

    assign bus.rf_we     = pop && head.we && !reset;
    assign bus.rf_waddr  = head.rd;
    assign bus.rf_wdata  = head.data;
    assign bus.fwd_valid = bus.out_valid && head.we;
    assign bus.fwd_rd    = head.rd;
    assign bus.fwd_data  = head.data;
    assign bus.commit_count = commit_count_q;

    wb_skid_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .pop        (pop),
        .flush      (bus.flush),
        .push_entry (in_entry),
        .head       (head),
        .state      (state)
    );

    // Count committed register writes, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)          commit_count_q <= '0;
        else if (bus.rf_we) commit_count_q <= commit_count_q + 32'd1;
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer: a vector table for single-entry flow
// plus hand sequences for stall, flush, counter wrap and reset.
module tb_wb_commit_buffer;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    wb_commit_buffer_if bus ();

    wb_commit_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic        ordy;
        logic        e_ov;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_fv;
        logic [31:0] e_cc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic iv, input logic [31:0] alu, input logic [31:0] mdata,
                         input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic ordy, input logic fl);
        bus.in_valid   = iv;
        bus.alu_result = alu;
        bus.mem_rdata  = mdata;
        bus.mem_to_reg = m2r;
        bus.reg_write  = rw;
        bus.rd         = rd;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " in_ready"},  32'(bus.in_ready), 32'd1);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " rf_we"},     32'(bus.rf_we), 32'd0);
        chk({tag, " rf_waddr"},  32'(bus.rf_waddr), 32'd0);
        chk({tag, " rf_wdata"},  bus.rf_wdata, 32'd0);
        chk({tag, " fwd_valid"}, 32'(bus.fwd_valid), 32'd0);
        chk({tag, " fwd_rd"},    32'(bus.fwd_rd), 32'd0);
        chk({tag, " fwd_data"},  bus.fwd_data, 32'd0);
        chk({tag, " count"},     bus.commit_count, 32'd0);
    endtask

    initial begin
        //          iv  alu           mdata          m2r rw rd  ordy  ov we waddr wdata          fv cc
        vecs[0] = '{1, 32'h0000_1234, 32'h0,         0,  1, 5,  1,    0, 0, 0,  32'h0,         0, 0};
        vecs[1] = '{1, 32'h0000_0001, 32'hDEAD_BEEF, 1,  1, 9,  1,    1, 1, 5,  32'h0000_1234, 1, 0};
        vecs[2] = '{1, 32'h0000_0001, 32'hDEAD_BEEF, 1,  1, 0,  1,    1, 1, 9,  32'hDEAD_BEEF, 1, 1};
        vecs[3] = '{1, 32'h0000_00A5, 32'h0,         0,  0, 12, 1,    1, 0, 0,  32'hDEAD_BEEF, 0, 2};
        vecs[4] = '{0, 32'h0,         32'h0,         0,  0, 0,  1,    1, 0, 12, 32'h0000_00A5, 0, 2};
        vecs[5] = '{0, 32'h0,         32'h0,         0,  0, 0,  1,    0, 0, 0,  32'h0,         0, 2};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_values("reset");

        // Single-entry flow through the table, out_ready held high.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].iv, vecs[i].alu, vecs[i].mdata, vecs[i].m2r, vecs[i].rw,
                  vecs[i].rd, vecs[i].ordy, 0);
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d rf_we", i),     32'(bus.rf_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d fwd_valid", i), 32'(bus.fwd_valid), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d count", i),     bus.commit_count, vecs[i].e_cc);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(vecs[i].e_waddr));
                chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d fwd_rd", i),   32'(bus.fwd_rd), 32'(vecs[i].e_waddr));
                chk($sformatf("v%0d fwd_data", i), bus.fwd_data, vecs[i].e_wdata);
            end
            @(negedge clk);
        end

        // Stall: fill to FULL with out_ready low, third offer held.
        drive(1, 32'h11, 0, 0, 1, 1, 0, 0);
        chk("stall in_ready0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1, 32'h22, 0, 0, 1, 2, 0, 0);
        chk("stall in_ready1", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1, 32'h33, 0, 0, 1, 3, 0, 0);
        chk("stall in_ready full", 32'(bus.in_ready), 32'd0);
        chk("stall rf_we", 32'(bus.rf_we), 32'd0);
        chk("stall fwd_rd", 32'(bus.fwd_rd), 32'd1);
        @(negedge clk);
        chk("stall head held rd", 32'(bus.rf_waddr), 32'd1);
        chk("stall head held data", bus.rf_wdata, 32'h11);
        drive(1, 32'h33, 0, 0, 1, 3, 1, 0);
        chk("drain0 rf_we", 32'(bus.rf_we), 32'd1);
        chk("drain0 waddr", 32'(bus.rf_waddr), 32'd1);
        chk("drain0 in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("drain1 rf_we", 32'(bus.rf_we), 32'd1);
        chk("drain1 waddr", 32'(bus.rf_waddr), 32'd2);
        chk("drain1 fwd_rd", 32'(bus.fwd_rd), 32'd2);
        chk("drain1 wdata", bus.rf_wdata, 32'h22);
        chk("drain1 in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain2 rf_we", 32'(bus.rf_we), 32'd1);
        chk("drain2 waddr", 32'(bus.rf_waddr), 32'd3);
        chk("drain2 wdata", bus.rf_wdata, 32'h33);
        @(negedge clk);
        chk("drain done out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain done count", bus.commit_count, 32'd5);

        // Flush while FULL drops the offered rd=7 and both entries.
        drive(1, 32'h44, 0, 0, 1, 4, 0, 0);
        @(negedge clk);
        drive(1, 32'h66, 0, 0, 1, 6, 0, 0);
        @(negedge clk);
        drive(1, 32'h77, 0, 0, 1, 7, 0, 1);
        chk("flush full in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush fwd_valid", 32'(bus.fwd_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush no write %0d", i), 32'(bus.rf_we), 32'd0);
            @(negedge clk);
            #1;
        end
        chk("flush count", bus.commit_count, 32'd5);

        // Head popping in the flush cycle still commits.
        drive(1, 32'h88, 0, 0, 1, 8, 0, 0);
        @(negedge clk);
        drive(1, 32'h99, 0, 0, 1, 10, 1, 1);
        chk("flush pop rf_we", 32'(bus.rf_we), 32'd1);
        chk("flush pop waddr", 32'(bus.rf_waddr), 32'd8);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("flush pop out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush pop count", bus.commit_count, 32'd6);

        // Counter wrap from a forced all-ones value.
        force dut.commit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_count_q;
        chk("preload count", bus.commit_count, 32'hFFFF_FFFF);
        drive(1, 32'h5A, 0, 0, 1, 10, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("wrap rf_we", 32'(bus.rf_we), 32'd1);
        @(negedge clk);
        #1;
        chk("wrap count", bus.commit_count, 32'h0000_0000);

        // Reset while FULL: no write in the reset cycle, reset values after.
        drive(1, 32'h12, 0, 0, 1, 2, 0, 0);
        @(negedge clk);
        drive(1, 32'h13, 0, 0, 1, 3, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 32'h14, 0, 0, 1, 4, 1, 1);
        chk("reset cycle rf_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_reset_values("reset full");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_commit_buffer.md
WB_COMMIT_BUFFER -- requirements
Module: wb_commit_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, MEM stage presents a result.
REQ-004 SHALL have port in_ready, output, 1, buffer accepts a result this cycle.
REQ-005 SHALL have port alu_result, input, 32, ALU result from MEM stage.
REQ-006 SHALL have port mem_rdata, input, 32, load data from data memory.
REQ-007 SHALL have ports mem_to_reg, input, 1 (1 = select mem_rdata), and reg_write, input, 1, register-write intent.
REQ-008 SHALL have port rd, input, 5, destination register.
REQ-009 SHALL have port flush, input, 1, discard all buffered entries.
REQ-010 SHALL have ports out_ready, input, 1, register-file write port free; out_valid, output, 1, head entry presented.
REQ-011 SHALL have ports rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, 32, register-file write port.
REQ-012 SHALL have ports fwd_valid, output, 1; fwd_rd, output, 5; fwd_data, output, 32, forwarding tap to the operand-select logic.
REQ-013 SHALL have port commit_count, output, 32, number of register writes committed.

Function
REQ-014 SHALL compute entry data at enqueue: mem_rdata if mem_to_reg=1, else alu_result; entry stores {data[31:0], rd[4:0], we}, we = reg_write AND (rd != 0).
REQ-015 SHALL hold at most 2 entries in FIFO order; state EMPTY (0), ONE (1), FULL (2).
REQ-016 SHALL drive in_ready = (state != FULL), derived from registered state only; no combinational in_valid-to-out path.
REQ-017 SHALL accept on in_valid AND in_ready; SHALL pop head on out_valid AND out_ready.
REQ-018 SHALL transition: accept only -> count+1; pop only -> count-1; accept and pop -> count unchanged, head advances, new entry enqueued at tail.
REQ-019 SHALL present an entry accepted in cycle N at the head no earlier than cycle N+1 (latency 1 when empty).
REQ-020 SHALL drive out_valid = (state != EMPTY); rf_waddr/rf_wdata = head rd/data; rf_we = out_valid AND out_ready AND head.we.
REQ-021 SHALL drive fwd_valid = out_valid AND head.we; fwd_rd/fwd_data = head rd/data; when FULL, head (oldest) entry is forwarded only.
REQ-022 SHALL pop entries with we=0 (reg_write=0 or rd=0) through the handshake without asserting rf_we.
REQ-023 SHALL increment commit_count by 1 per cycle with rf_we=1; wrap 0xFFFFFFFF -> 0x00000000.
REQ-024 SHALL on flush: next state EMPTY, out_valid/fwd_valid 0 next cycle; input offered in the flush cycle is dropped; rf_we still asserted in the flush cycle if the head pops that cycle (head write is committed).
REQ-025 SHALL hold head stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL on reset: state EMPTY, in_ready 1, out_valid 0, rf_we 0, rf_waddr 0, rf_wdata 0, fwd_valid 0, fwd_rd 0, fwd_data 0, commit_count 0; reset overrides flush and all handshakes.
REQ-027 SHALL discard in-flight entries on reset mid-operation with no rf_we pulse in the reset cycle.

Structure
REQ-028 SHALL place state encoding (EMPTY/ONE/FULL), DATA_W=32, REG_W=5, REG_ZERO=5'd0 in shared package wb_pkg.
REQ-029 SHALL implement the 2-entry storage and pointers as sub-module wb_skid_fifo; writeback select and we-qualification remain in the top.

Verification
REQ-030 SHALL verify: reset, then in_valid=1, alu_result=0x0000_1234, rd=5, reg_write=1, mem_to_reg=0, out_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234, commit_count=1.
REQ-031 SHALL verify: mem_to_reg=1, mem_rdata=0xDEAD_BEEF, alu_result=0x1, rd=9 -> rf_wdata=0xDEAD_BEEF; same with rd=0 -> out_valid=1, rf_we=0, fwd_valid=0, commit_count unchanged.
REQ-032 SHALL verify: out_ready=0, three back-to-back in_valid (rd=1,2,3) -> in_ready=0 after two accepts, third held; out_ready=1 -> writes rd=1,2,3 in order, fwd_rd follows head.
REQ-033 SHALL verify: FULL state, flush=1 with in_valid=1 (rd=7) -> next cycle out_valid=0, in_ready=1, rd=7 never written.
REQ-034 SHALL verify: commit_count preloaded by 2^32-1 writes (or forced) at 0xFFFFFFFF, one write -> 0x00000000; reset asserted while FULL -> all outputs at reset values next cycle.
